// File: rtl/dav_pkg.sv
// Shared types and constants for the display/audio-visualiser FFT path.
package dav_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNAP    = 3'd1,
    RST     = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4,
    PUBLISH = 3'd5,
    TMO     = 3'd6
  } fft_sched_state_t;

  localparam int DEFAULT_CNT_W = 8;

  // Largest of three durations; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request unless already at the ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Sequences one FFT frame per display-frame request: snapshot, core reset,
// core start, bounded wait for done, then a one-cycle "fresh spectrum" strobe.
// Keeps a one-deep pending request plus overrun/timeout accounting.
module fft_frame_scheduler
  import dav_pkg::*;
#(
  parameter int RST_CYCLES   = 2,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_req,
  input  logic             fft_done,
  output logic             snap_en,
  output logic             fft_rst,
  output logic             fft_start,
  output logic             frame_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_id,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             err
);

  localparam int PH_MAX = max3(RST_CYCLES, START_CYCLES, TIMEOUT);
  localparam int PH_W   = $clog2(PH_MAX);

  localparam logic [PH_W-1:0] RST_LAST   = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] START_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0] WAIT_LAST  = PH_W'(TIMEOUT - 1);

  fft_sched_state_t state, next_state;
  logic [PH_W-1:0]  phase, phase_next;
  logic             pending, pending_next;
  logic             start_req;
  logic             overrun_inc;
  logic             timeout_inc;
  logic             snap_d, fft_rst_d, fft_start_d, frame_valid_d, busy_d;

  // A disabled scheduler treats frame_req as if it never happened.
  assign start_req   = frame_req && enable;
  // A second request while one is already owed is dropped and counted.
  assign overrun_inc = start_req && (state != IDLE) && pending;
  assign timeout_inc = (state == WAIT) && (next_state == TMO);

  // State, phase counter and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= next_state;
      phase   <= phase_next;
      pending <= pending_next;
    end
  end

  // Next-state, phase and pending-request logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending || start_req) next_state = SNAP;
      SNAP:    next_state = RST;
      RST:     if (phase == RST_LAST) next_state = START;
      START:   if (phase == START_LAST) next_state = WAIT;
      // A done arriving on the last allowed cycle still wins over the timeout.
      WAIT: begin
        if (fft_done)                next_state = PUBLISH;
        else if (phase == WAIT_LAST) next_state = TMO;
      end
      PUBLISH: next_state = IDLE;
      TMO:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // The phase counter restarts at zero on every state change.
    phase_next = '0;
    if ((next_state == state) &&
        ((state == RST) || (state == START) || (state == WAIT))) begin
      phase_next = phase + PH_W'(1);
    end

    // In IDLE the owed frame is consumed; a request on that same cycle is
    // re-owed. Anywhere else a request is parked in the one-deep slot.
    if (state == IDLE) pending_next = pending && start_req;
    else               pending_next = pending || start_req;
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    snap_d        = (next_state == SNAP);
    fft_rst_d     = (next_state == RST);
    fft_start_d   = (next_state == START);
    frame_valid_d = (next_state == PUBLISH);
    busy_d        = (next_state != IDLE);
  end

  // Output registers; the core is held in reset until the first clock after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_en     <= 1'b0;
      fft_rst     <= 1'b1;
      fft_start   <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      frame_id    <= '0;
      err         <= 1'b0;
    end else begin
      snap_en     <= snap_d;
      fft_rst     <= fft_rst_d;
      fft_start   <= fft_start_d;
      frame_valid <= frame_valid_d;
      busy        <= busy_d;
      if ((state == WAIT) && (next_state == PUBLISH)) frame_id <= frame_id + CNT_W'(1);
      if (timeout_inc) err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_overrun_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (overrun_inc),
    .count (overrun_cnt)
  );

  sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (timeout_inc),
    .count (timeout_cnt)
  );

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: a schedule-based reference model (frame start
// cycle plus arithmetic offsets) checked every cycle, directed scenarios with
// literal expectations, randomized traffic, and a narrow-counter instance.
module tb_fft_frame_scheduler;

  localparam int R    = 2;
  localparam int S    = 1;
  localparam int T    = 64;
  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, frame_req = 1'b0, fft_done = 1'b0;
  logic snap_en, fft_rst, fft_start, frame_valid, busy, err;
  logic [W-1:0] frame_id, overrun_cnt, timeout_cnt;

  logic en2 = 1'b0, req2 = 1'b0, done2 = 1'b0;
  logic snap2, frst2, fstart2, valid2, busy2, err2;
  logic [1:0] fid2, ovr2, tmo2;

  fft_frame_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_req(frame_req), .fft_done(fft_done),
    .snap_en(snap_en), .fft_rst(fft_rst), .fft_start(fft_start), .frame_valid(frame_valid),
    .busy(busy), .frame_id(frame_id), .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt),
    .err(err)
  );

  fft_frame_scheduler #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .frame_req(req2), .fft_done(done2),
    .snap_en(snap2), .fft_rst(frst2), .fft_start(fstart2), .frame_valid(valid2),
    .busy(busy2), .frame_id(fid2), .overrun_cnt(ovr2), .timeout_cnt(tmo2),
    .err(err2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int c = 0;

  // Reference model: a frame is described by its snapshot cycle s and its
  // ending cycle e (publish or timeout); everything else follows by offsets.
  int s, e, m_fid, m_ovr, m_tmo;
  bit m_pend, m_pub, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, c, act, exp);
    end
  endtask

  function automatic bit m_busy(input int cc);
    return (s >= 0) && (cc >= s) && ((e < 0) || (cc <= e));
  endfunction

  task automatic model_reset();
    s = -1; e = -1; m_fid = 0; m_ovr = 0; m_tmo = 0;
    m_pend = 0; m_pub = 0; m_err = 0; c = 0;
  endtask

  task automatic model_compare();
    bit xs, xr, xst, xv, xb;
    xb  = m_busy(c);
    xs  = (s >= 0) && (c == s);
    xr  = (c == 0) || ((s >= 0) && (c >= s + 1) && (c <= s + R));
    xst = (s >= 0) && (c >= s + R + 1) && (c <= s + R + S);
    xv  = m_pub && (e == c);
    chk("strobes{snap,rst,start,valid,busy}",
        32'({snap_en, fft_rst, fft_start, frame_valid, busy}), 32'({xs, xr, xst, xv, xb}));
    chk("frame_id", 32'(frame_id), 32'(m_fid));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tmo));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_update(input bit rq, input bit dn);
    int w;
    w = s + R + S + 1;
    if (m_busy(c)) begin
      if (rq) begin
        if (m_pend) m_ovr = (m_ovr == MAXC) ? MAXC : m_ovr + 1;
        else        m_pend = 1;
      end
      if ((e < 0) && (c >= w)) begin
        if (dn) begin
          e = c + 1; m_pub = 1; m_fid = (m_fid + 1) % (MAXC + 1);
        end else if (c == w + T - 1) begin
          e = c + 1; m_pub = 0; m_err = 1;
          m_tmo = (m_tmo == MAXC) ? MAXC : m_tmo + 1;
        end
      end
    end else if (m_pend || rq) begin
      s = c + 1; e = -1; m_pend = m_pend && rq;
    end
  endtask

  // One clock cycle: compare current outputs, apply inputs, advance.
  task automatic cyc(input bit rq, input bit dn);
    model_compare();
    frame_req = rq;
    fft_done  = dn;
    model_update(rq && enable, dn);
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_req = 1'b0; fft_done = 1'b0; req2 = 1'b0; done2 = 1'b0;
    @(negedge clk);
    chk("reset_fft_rst", 32'(fft_rst), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_counters", 32'({frame_id, overrun_cnt, timeout_cnt}), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsnap;
    bit saw;

    // Nominal frame: request at 10, done 3 cycles into WAIT.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 11) chk("t1_snap_at_11", 32'(snap_en), 32'd1);
      if (i == 12 || i == 13) chk("t1_fft_rst_12_13", 32'(fft_rst), 32'd1);
      if (i == 14) chk("t1_start_at_14", 32'(fft_start), 32'd1);
      if (i == 19) chk("t1_valid_id_at_19", 32'({frame_valid, frame_id}), 32'h101);
      if (i == 20) chk("t1_idle_at_20", 32'(busy), 32'd0);
      cyc(i == 10, i == 18);
    end

    // fft_done held high throughout: publish only after reaching WAIT.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 7) chk("t2_no_early_valid", 32'({frame_valid, busy}), 32'b01);
      if (i == 8) chk("t2_valid_at_8", 32'({frame_valid, frame_id}), 32'h101);
      cyc(i == 2, 1'b1);
    end

    // No done at all: timeout after 64 WAIT cycles.
    do_reset();
    for (int i = 0; i < 75; i++) begin
      if (i == 70) chk("t3_still_waiting", 32'({busy, timeout_cnt}), 32'h100);
      if (i == 71) chk("t3_tmo_state", 32'({frame_valid, frame_id, timeout_cnt, err}), 32'h003);
      if (i == 72) chk("t3_idle_after_tmo", 32'(busy), 32'd0);
      cyc(i == 2, 1'b0);
    end

    // Three requests during WAIT: one pends, two overrun.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i == 11) chk("t4_overrun_2", 32'(overrun_cnt), 32'd2);
      if (i == 13) chk("t4_publish", 32'(frame_valid), 32'd1);
      if (i == 14) chk("t4_one_idle", 32'({busy, snap_en}), 32'd0);
      if (i == 15) chk("t4_pending_snap", 32'(snap_en), 32'd1);
      cyc(i == 2 || i == 8 || i == 9 || i == 10, i == 12);
    end

    // Disabled: requests every 5 cycles are ignored completely.
    do_reset();
    enable = 1'b0;
    nsnap = 0;
    for (int i = 0; i < 100; i++) begin
      if (snap_en) nsnap++;
      cyc(i % 5 == 0, 1'b0);
    end
    chk("t5_no_snap", 32'(nsnap), 32'd0);
    chk("t5_no_overrun", 32'(overrun_cnt), 32'd0);

    // Asynchronous reset in the middle of START.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cyc(i == 2, 1'b0);
    chk("t6_in_start", 32'(fft_start), 32'd1);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset", 32'({fft_rst, fft_start, busy}), 32'b100);

    // Randomized traffic, done rate varying per block (rate 0 = never).
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int drate;
      drate = $urandom_range(0, 4);
      for (int i = 0; i < 200; i++) begin
        enable = ($urandom_range(0, 9) != 0);
        cyc($urandom_range(0, 7) == 0, (drate != 0) && ($urandom_range(1, drate * 3) == 1));
      end
    end
    model_compare();

    // Narrow counters: frame_id wraps, timeout_cnt saturates.
    do_reset();
    en2 = 1'b1;
    done2 = 1'b1;
    for (int f = 0; f < 5; f++) begin
      req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 40 && !saw; k++) begin
        @(negedge clk);
        saw = valid2;
      end
      chk("t8_publish_seen", 32'(saw), 32'd1);
      chk("t8_frame_id", 32'(fid2), 32'((f + 1) % 4));
      @(negedge clk);
    end
    chk("t8_frame_id_wrapped", 32'(fid2), 32'd1);
    done2 = 1'b0;
    for (int f = 0; f < 5; f++) begin
      req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      for (int k = 0; k < 72; k++) @(negedge clk);
      chk("t8_tmo_idle", 32'(busy2), 32'd0);
      chk("t8_timeout_cnt", 32'(tmo2), 32'((f + 1 > 3) ? 3 : f + 1));
    end
    chk("t8_err_sticky", 32'({err2, fid2}), 32'b101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
